// File: rtl/rv_pkg.sv
// Shared RISC-V core definitions: default widths, register counts and the
// architectural zero-register address.
package rv_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int NREGS_RV32I  = 32;
  localparam int NREGS_RV32E  = 16;

  typedef logic [4:0]              reg_addr_t;
  typedef logic [XLEN_DEFAULT-1:0] xword_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  function automatic logic is_zero_addr(input reg_addr_t addr);
    return addr == REG_ZERO;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One register-file read port: write-first bypass against every write port,
// x0 gating and an optional output register.
module regfile_rdport
  import rv_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int AW       = 5,
  parameter int NWR      = 1,
  parameter int RD_LAT   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_rd_en,
  input  logic [AW-1:0]     i_rd_addr,
  input  logic [XLEN-1:0]   i_rd_raw,
  input  logic [NWR-1:0]    i_wr_keep,
  input  logic [NWR*AW-1:0] i_wr_addr,
  input  logic [NWR*XLEN-1:0] i_wr_data,
  output logic [XLEN-1:0]   o_rd_data,
  output logic              o_rd_valid
);

  logic [XLEN-1:0] w_bypassed;

  // Ascending scan so the highest-index matching write port supplies the data.
  always_comb begin
    w_bypassed = i_rd_raw;
    for (int j = 0; j < NWR; j++) begin
      if (i_wr_keep[j] && (i_wr_addr[j*AW +: AW] == i_rd_addr)) begin
        w_bypassed = i_wr_data[j*XLEN +: XLEN];
      end
    end
    if ((ZERO_REG != 0) && is_zero_addr(reg_addr_t'(i_rd_addr))) begin
      w_bypassed = '0;
    end
  end

  generate
    if (RD_LAT == 1) begin : g_reg
      logic [XLEN-1:0] r_data;
      logic            r_valid;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_data  <= '0;
          r_valid <= 1'b0;
        end else begin
          r_valid <= i_rd_en;
          if (i_rd_en) begin
            r_data <= w_bypassed;
          end
        end
      end

      assign o_rd_data  = r_data;
      assign o_rd_valid = r_valid;
    end else begin : g_comb
      assign o_rd_data  = w_bypassed;
      assign o_rd_valid = i_rd_en;
    end
  endgenerate

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file: storage and write logic,
// with one regfile_rdport per read port.
module regfile_mp
  import rv_pkg::*;
#(
  parameter  int XLEN     = XLEN_DEFAULT,
  parameter  int NREGS    = NREGS_RV32I,
  parameter  int NRD      = 2,
  parameter  int NWR      = 1,
  parameter  int RD_LAT   = 1,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_valid,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data
);

  generate
    if ((NRD < 1) || (NRD > 4) || (NWR < 1) || (NWR > 2) ||
        ((RD_LAT != 0) && (RD_LAT != 1)) ||
        ((NREGS != NREGS_RV32I) && (NREGS != NREGS_RV32E))) begin : g_bad_param
      $error("regfile_mp: illegal parameter combination");
    end
  endgenerate

  logic [XLEN-1:0] r_regs [NREGS];
  logic [NWR-1:0]  w_wr_keep;

  genvar gi;
  generate
    for (gi = 0; gi < NWR; gi++) begin : g_wr_keep
      assign w_wr_keep[gi] = wr_en[gi] &&
        !((ZERO_REG != 0) && is_zero_addr(reg_addr_t'(wr_addr[gi*AW +: AW])));
    end
  endgenerate

  // Later loop iterations override earlier ones: higher write port wins a collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NREGS; k++) begin
        r_regs[k] <= '0;
      end
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (w_wr_keep[j]) begin
          r_regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rdport
      logic [XLEN-1:0] w_rd_raw;
      assign w_rd_raw = r_regs[rd_addr[gi*AW +: AW]];

      regfile_rdport #(
        .XLEN     (XLEN),
        .AW       (AW),
        .NWR      (NWR),
        .RD_LAT   (RD_LAT),
        .ZERO_REG (ZERO_REG)
      ) u_rdport (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rd_en    (rd_en[gi]),
        .i_rd_addr  (rd_addr[gi*AW +: AW]),
        .i_rd_raw   (w_rd_raw),
        .i_wr_keep  (w_wr_keep),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .o_rd_data  (rd_data[gi*XLEN +: XLEN]),
        .o_rd_valid (rd_valid[gi])
      );
    end
  endgenerate

endmodule
